alu_ctrl_md: RTL and testbench

- Next-generation ALU controller for the RV32 datapath.
- Combinationally decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code used across the core.
- Adds R/I-type disambiguation, an SLTU code, and a multi-cycle iterative multiply/divide engine for RV32M.
- While the engine runs, it stalls the pipeline and returns its result through a valid pulse.

---
 rtl/alu_ctrl_md.sv | 169 ++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: RV32 ALU control decode plus an iterative RV32M multiply/divide
// engine. The engine stalls the pipeline while it runs and returns its result
// with a one-cycle md_valid pulse.
// Optional build macro: ALU_MD_RADIX4_EN retires two multiplier bits per cycle
// on MUL*. Divide always uses one quotient bit per cycle.
module alu_ctrl_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            RType,
  input  logic            in_valid,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   opnd;     // multiplicand (mul) or divisor (div), magnitude
  logic [2*XLEN-1:0] acc;      // {hi, lo}: product/multiplier or remainder/quotient

  logic            is_mop, accept, div0, last;
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] amag, bmag;

  assign is_mop = (ALUOp == 2'b10) && RType && (Funct7 == 7'b0000001);
  assign accept = (state == IDLE) && in_valid && is_mop;
  assign div0   = Funct3[2] && (SrcB == '0);

  // ALU operation decode; an M-op overrides the integer table
  always_comb begin
    Operation = 4'b0010;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b01: begin
        case (Funct3)
          3'b001:  Operation = 4'b1001;
          3'b100:  Operation = 4'b1010;
          3'b101:  Operation = 4'b1011;
          default: Operation = 4'b1000;
        endcase
      end
      2'b11: Operation = 4'b0101;
      default: begin
        case (Funct3)
          3'b000:  Operation = (RType && Funct7 == 7'b0100000) ? 4'b0011 : 4'b0010;
          3'b001:  Operation = 4'b0100;
          3'b010:  Operation = 4'b1100;
          3'b011:  Operation = 4'b1110;
          3'b100:  Operation = 4'b0110;
          3'b101:  Operation = (Funct7 == 7'b0100000) ? 4'b0111 : 4'b0101;
          3'b110:  Operation = 4'b0001;
          default: Operation = 4'b0000;
        endcase
      end
    endcase
    if (is_mop) Operation = 4'b1111;
  end

  // Operand signedness and magnitudes at accept; MUL low half is sign-agnostic
  always_comb begin
    a_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    sa    = a_sgn && SrcA[XLEN-1];
    sb    = b_sgn && SrcB[XLEN-1];
    amag  = sa ? -SrcA : SrcA;
    bmag  = sb ? -SrcB : SrcB;
  end

  // One iteration step and the fixed-up result of the final step
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, prod;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   quo, rem, res;
`ifdef ALU_MD_RADIX4_EN
  logic [XLEN+1:0]   msum;
`else
  logic [XLEN:0]     msum;
`endif

  always_comb begin
`ifdef ALU_MD_RADIX4_EN
    msum   = {2'b00, acc[2*XLEN-1:XLEN]}
           + (acc[0] ? {2'b00, opnd} : '0)
           + (acc[1] ? {1'b0, opnd, 1'b0} : '0);
    mul_nx = {msum, acc[XLEN-1:2]};
    last   = f3[2] ? (cnt == CNT_W'(XLEN-1)) : (cnt == CNT_W'(XLEN/2-1));
`else
    msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx = {msum, acc[XLEN-1:1]};
    last   = (cnt == CNT_W'(XLEN-1));
`endif
    // restoring divide: shift in next dividend bit, keep difference if no borrow
    trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
    div_nx = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                         : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nx = f3[2] ? div_nx : mul_nx;
    prod   = neg_q ? -acc_nx : acc_nx;
    quo    = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem    = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    if (f3[2])            res = f3[1] ? rem : quo;
    else if (f3 == 3'b000) res = prod[XLEN-1:0];
    else                   res = prod[2*XLEN-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state; divide by zero skips RUN entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = div0 ? DONE : RUN;
      RUN:     if (last)   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs; stall covers the accept cycle and every RUN cycle
  always_comb begin
    stall    = accept || (state == RUN);
    md_valid = (state == DONE);
  end

  // Engine datapath: latch operands on accept, iterate in RUN, register result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      f3        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      md_result <= '0;
    end else if (accept) begin
      cnt   <= '0;
      f3    <= Funct3;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (Funct3[2]) begin
        opnd <= bmag;
        acc  <= {{XLEN{1'b0}}, amag};
      end else begin
        opnd <= amag;
        acc  <= {{XLEN{1'b0}}, bmag};
      end
      if (div0) md_result <= Funct3[1] ? SrcA : '1;
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) md_result <= res;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: directed and random checks of alu_ctrl_md decode and the
// RV32M engine against a 64-bit arithmetic reference model.
module tb_alu_ctrl_md;

  localparam int XLEN = 32;
`ifdef ALU_MD_RADIX4_EN
  localparam int MUL_LAT = XLEN/2 + 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            RType;
  logic            in_valid;
  logic [XLEN-1:0] SrcA, SrcB;
  logic [3:0]      Operation;
  logic            stall, md_valid;
  logic [XLEN-1:0] md_result;

  int checks   = 0;
  int failures = 0;

  alu_ctrl_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .RType(RType), .in_valid(in_valid), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .stall(stall), .md_valid(md_valid), .md_result(md_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // RV32M results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = longint'(({32'b0, a} * {32'b0, b}) >> 32);
      3'd4: r = (b == 0) ? -1 : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  // Operation code table
  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic rt);
    if (op == 2'b10 && rt && f7 == 7'h01) return 4'hF;
    if (op == 2'b00) return 4'h2;
    if (op == 2'b11) return 4'h5;
    if (op == 2'b01) return (f3 == 3'd1) ? 4'h9 : (f3 == 3'd4) ? 4'hA : (f3 == 3'd5) ? 4'hB : 4'h8;
    case (f3)
      3'd0: return (rt && f7 == 7'h20) ? 4'h3 : 4'h2;
      3'd1: return 4'h4;
      3'd2: return 4'hC;
      3'd3: return 4'hE;
      3'd4: return 4'h6;
      3'd5: return (f7 == 7'h20) ? 4'h7 : 4'h5;
      3'd6: return 4'h1;
      default: return 4'h0;
    endcase
  endfunction

  task automatic decode(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic rt);
    @(negedge clk);
    ALUOp = op; Funct3 = f3; Funct7 = f7; RType = rt; in_valid = 1'b1;
    #1;
    chk({tag, " op"}, 32'(Operation), 32'(ref_op(op, f3, f7, rt)));
    chk({tag, " stall"}, 32'(stall), 0);
    @(negedge clk);
    chk({tag, " no md_valid"}, 32'(md_valid), 0);
    in_valid = 1'b0;
  endtask

  // Issue one M-op, then check stall/md_valid every cycle up to the pulse
  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = ref_md(f3, a, b);
    lat = (f3[2] && b == 0) ? 1 : (f3[2] ? DIV_LAT : MUL_LAT);
    @(negedge clk);
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01; Funct3 = f3; SrcA = a; SrcB = b; in_valid = 1'b1;
    #1;
    chk({tag, " accept stall"}, 32'(stall), 1);
    chk({tag, " accept op"}, 32'(Operation), 32'hF);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({tag, " md_valid"}, 32'(md_valid), 32'(k == lat));
      chk({tag, " stall"}, 32'(stall), 32'(k < lat));
      if (k == lat) chk({tag, " result"}, md_result, exp);
      in_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    end
    @(negedge clk);
    chk({tag, " pulse ends"}, 32'(md_valid), 0);
    chk({tag, " result held"}, md_result, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [1:0]  op;
    logic        rt, seen;
    rst_n = 1'b0; in_valid = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    RType = 1'b0; SrcA = '0; SrcB = '0;
    #1;
    chk("reset md_valid", 32'(md_valid), 0);
    chk("reset md_result", md_result, 0);
    chk("reset stall", 32'(stall), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // decode directed
    decode("addi f7=20", 2'b10, 3'd0, 7'h20, 1'b0);
    decode("sub", 2'b10, 3'd0, 7'h20, 1'b1);
    decode("sltu", 2'b10, 3'd3, 7'h00, 1'b1);
    decode("bge", 2'b01, 3'd5, 7'h00, 1'b0);
    decode("srai", 2'b10, 3'd5, 7'h20, 1'b0);
    decode("lui", 2'b11, 3'd2, 7'h01, 1'b1);
    // decode random, M-op pattern excluded so nothing is accepted
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom); f3 = 3'($urandom); rt = 1'($urandom);
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      if (op == 2'b10 && rt && f7 == 7'h01) f7 = 7'h00;
      decode("rand dec", op, f3, f7, rt);
    end

    // directed M-ops
    run_mop("MUL 7*-3", 3'd0, 32'd7, 32'hFFFFFFFD);
    run_mop("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mop("MULHSU", 3'd2, 32'hFFFFFFFF, 32'h00000002);
    run_mop("MULH", 3'd1, 32'h80000000, 32'h80000000);
    run_mop("DIV 20/0", 3'd4, 32'd20, 32'd0);
    run_mop("REM 20/0", 3'd6, 32'd20, 32'd0);
    run_mop("DIVU 20/0", 3'd5, 32'hFFFFFFF0, 32'd0);
    run_mop("REMU 20/0", 3'd7, 32'hFFFFFFF0, 32'd0);
    run_mop("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_mop("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_mop("REM -7/2", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_mop("DIV -7/2", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_mop("DIVU 100/7", 3'd5, 32'd100, 32'd7);
    run_mop("REMU big", 3'd7, 32'hFFFFFFFF, 32'h00010001);

    // random M-ops
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_mop("rand md", f3, a, b);
    end

    // reset mid-RUN
    @(negedge clk);
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01; Funct3 = 3'd4;
    SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("abort md_valid", 32'(md_valid), 0);
    chk("abort stall", 32'(stall), 0);
    chk("abort md_result", md_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_valid || stall) seen = 1'b1;
    end
    chk("no pulse after abort", 32'(seen), 0);
    run_mop("MUL 3*5", 3'd0, 32'd3, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
